shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Sequencer for the 4-bit serial-in shift register datapath.
- Accepts a parallel word over a valid/ready handshake and serialises it MSB-first onto the register's serial input.
- Each bit is held for a programmable number of clocks; a shift-enable strobe tells the downstream register when to sample.
- Signals completion with a one-cycle done pulse; the register's parallel output then holds the transferred word.

Parameters:
- WIDTH, 4, bits per transfer (equals the shift register width).
- DIV_W, 8, width of the bit-period divider input.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  requester has a word to send.
- in_ready  out  1  controller can accept a word.
- in_data  in  WIDTH  word to serialise, MSB sent first.
- div  in  DIV_W  bit period minus 1, in clocks; sampled at accept.
- abort  in  1  synchronous cancel of the current transfer.
- serial_out  out  1  drives the shift register serial input.
- shift_en  out  1  one-cycle strobe; downstream register shifts on this cycle.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse when a transfer completes.
- bit_cnt  out  clog2(WIDTH)+1  number of bits already shifted in the current transfer.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs go immediately to: state IDLE, serial_out=0, shift_en=0, busy=0, done=0, bit_cnt=0, in_ready=1.
  - Internal buffer and divider counter clear to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, serial_out=0.
  - Accept occurs when in_valid & in_ready at edge T:
    - buf<=in_data, div_q<=div, tick<=div, bit_cnt<=0, state<=SHIFT.
- SHIFT:
  - in_ready=0, busy=1, serial_out=buf[WIDTH-1].
  - tick decrements each cycle.
  - On the cycle where tick==0:
    - shift_en=1.
    - At the edge: buf<=buf<<1, bit_cnt+1, tick<=div_q.
    - If bit_cnt==WIDTH-1, state<=DONE.
- Timing:
  - Each bit is held for div_q+1 cycles.
  - shift_en is high on cycles T+(k+1)(div_q+1), for k=0..WIDTH-1.
- DONE:
  - Lasts exactly 1 cycle (cycle T+WIDTH*(div_q+1)+1).
  - done=1, busy=1, in_ready=0, serial_out=0, bit_cnt=WIDTH.
  - Next state is IDLE; bit_cnt<=0.
- Latency and throughput:
  - First bit appears on serial_out at T+1.
  - done at T+WIDTH*(div_q+1)+1.
  - Minimum spacing between accepts is WIDTH*(div_q+1)+2 cycles (one mandatory IDLE cycle).
- div=0: one clock per bit; shift_en stays high for WIDTH consecutive cycles.
- div=max (2^DIV_W-1): counter must not overflow; bits last 2^DIV_W cycles.
- Changes to div or in_data after accept have no effect on the transfer in progress.
- in_valid while busy: ignored, no state change, no word queued.
- abort:
  - In SHIFT: next state IDLE, shift_en forced 0 on the abort cycle, done not pulsed, bit_cnt<=0, serial_out=0 from the next cycle.
  - In IDLE or DONE: no effect.
  - abort has priority over accept and over completion in the same cycle.
- Reset mid-transfer: asynchronous clear as above, no done pulse; the first accept after rst returns to 1 behaves normally.
- Downstream register contract: it shifts only when shift_en=1 and samples serial_out on that edge. After done, its parallel output equals the accepted in_data.

Test Plan:
- Reset check: rst=0 at an arbitrary time mid-clock -> serial_out=0, busy=0, done=0, in_ready=1, bit_cnt=0 without waiting for a clock edge.
- Single transfer, WIDTH=4, div=0, in_data=4'hA accepted at T:
  - serial_out=1,0,1,0 on T+1..T+4.
  - shift_en high T+1..T+4.
  - done only at T+5.
  - Register output = 4'hA.
- Divided rate, div=2, in_data=4'h3:
  - Each bit held 3 cycles.
  - shift_en only at T+3, T+6, T+9, T+12.
  - done at T+13.
  - Register output = 4'h3.
- Busy rejection: hold in_valid=1 with 4'h5 during a 4'hC transfer:
  - in_ready=0 throughout.
  - 4'hC completes intact.
  - 4'h5 is accepted on the first IDLE cycle after done.
- Abort: div=1, assert abort during bit 2 ->
  - No shift_en on the abort cycle.
  - Next cycle IDLE, bit_cnt=0, no done pulse.
  - A new 4'h9 transfer then completes correctly.
- Async reset mid-shift: rst=0 during bit 1 of 4'hF ->
  - Immediate reset values, no done.
  - After release, a 4'h6 transfer at div=0 finishes at T+5 with register=4'h6.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Sequencer for a serial-in shift register. It accepts a parallel word over
//   a valid/ready handshake and sends it MSB-first on serial_out. Each bit is
//   held for div+1 clocks. shift_en tells the downstream register which cycle
//   to sample on. done pulses for one cycle when the whole word has gone out.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low (0 = reset)
//   in_valid   : requester has a word to send
//   in_ready   : controller can accept a word (IDLE only)
//   in_data    : word to serialise, MSB first
//   div        : bit period minus one, in clocks; captured at accept
//   abort      : synchronous cancel of a transfer in progress
//   serial_out : serial data to the shift register input
//   shift_en   : one-cycle strobe; downstream register shifts on this cycle
//   busy       : high in SHIFT and DONE
//   done       : one-cycle completion pulse
//   bit_cnt    : bits already shifted in the current transfer
module shift_seq_ctrl #(
    parameter  int WIDTH = 4,
    parameter  int DIV_W = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [DIV_W-1:0] div,
    input  logic             abort,
    output logic             serial_out,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_buf_q, shift_buf_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   tick_q, tick_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               serial_out_q, serial_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               in_ready_q, in_ready_d;
    logic               tick_zero;

    assign tick_zero = (tick_q == '0);

    always_comb begin
        state_d     = state_q;
        shift_buf_d = shift_buf_q;
        div_d       = div_q;
        tick_d      = tick_q;
        bit_cnt_d   = bit_cnt_q;

        case (state_q)
            S_IDLE: begin
                // in_ready is always high in IDLE, so valid alone accepts.
                if (in_valid) begin
                    shift_buf_d = in_data;
                    div_d       = div;
                    tick_d      = div;
                    bit_cnt_d   = '0;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // abort outranks both the shift and the completion.
                if (abort) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                end else if (tick_zero) begin
                    shift_buf_d = {shift_buf_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                    tick_d      = div_q;
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    // tick reloads from div_q before it would wrap.
                    tick_d = tick_q - DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        in_ready_d   = (state_d == S_IDLE);
        serial_out_d = (state_d == S_SHIFT) ? shift_buf_d[WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            shift_buf_q  <= '0;
            div_q        <= '0;
            tick_q       <= '0;
            bit_cnt_q    <= '0;
            serial_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_buf_q  <= shift_buf_d;
            div_q        <= div_d;
            tick_q       <= tick_d;
            bit_cnt_q    <= bit_cnt_d;
            serial_out_q <= serial_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // The strobe has to drop in the same cycle abort is raised, so it is
    // decoded from state rather than registered.
    assign shift_en   = (state_q == S_SHIFT) && tick_zero && !abort;
    assign serial_out = serial_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign in_ready   = in_ready_q;
    assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl, with a model of the downstream 4-bit
// serial-in shift register.
module tb_shift_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [7:0] div;
    logic       abort;
    logic       serial_out;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic [2:0] bit_cnt;

    int total;
    int bad;

    logic [3:0] sreg;

    shift_seq_ctrl #(.WIDTH(4), .DIV_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .div        (div),
        .abort      (abort),
        .serial_out (serial_out),
        .shift_en   (shift_en),
        .busy       (busy),
        .done       (done),
        .bit_cnt    (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register: shifts in serial_out only when shift_en is high.
    initial sreg = 4'h0;
    always @(posedge clk) begin
        if (shift_en) sreg <= {sreg[2:0], serial_out};
    end

    typedef struct {
        logic [3:0] data;
        logic [7:0] dv;
        int         exp_done;
        logic [3:0] exp_reg;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (in_ready !== 1'b1) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Accept a word, then check every cycle of the transfer up to and one past done.
    task automatic run_xfer(input logic [3:0] d, input logic [7:0] dv, input int exp_done,
                            input logic [3:0] exp_reg, input bit hold, output int waited);
        int per;
        int k;
        logic exp_se;
        logic exp_so;
        wait_ready(waited);
        if (in_ready !== 1'b1) return;
        in_valid = 1'b1;
        in_data  = d;
        div      = dv;
        step();
        if (hold) begin
            in_data = 4'h5;
            div     = 8'd0;
        end else begin
            in_valid = 1'b0;
            in_data  = ~d;
            div      = ~dv;
        end
        per = int'(dv) + 1;
        for (int c = 1; c <= exp_done; c++) begin
            k      = (c - 1) / per;
            exp_se = (c < exp_done) && ((c % per) == 0);
            exp_so = (c < exp_done) ? d[3 - k] : 1'b0;
            chk("busy",       {31'd0, busy},       32'd1);
            chk("in_ready",   {31'd0, in_ready},   32'd0);
            chk("shift_en",   {31'd0, shift_en},   {31'd0, exp_se});
            chk("serial_out", {31'd0, serial_out}, {31'd0, exp_so});
            chk("done",       {31'd0, done},       {31'd0, (c == exp_done)});
            chk("bit_cnt",    {29'd0, bit_cnt},    32'(k));
            if (c == exp_done) chk("reg_out", {28'd0, sreg}, {28'd0, exp_reg});
            step();
        end
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_busy",  {31'd0, busy},     32'd0);
        chk("idle_done",  {31'd0, done},     32'd0);
        chk("idle_cnt",   {29'd0, bit_cnt},  32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_serial_out"}, {31'd0, serial_out}, 32'd0);
        chk({tag, "_shift_en"},   {31'd0, shift_en},   32'd0);
        chk({tag, "_busy"},       {31'd0, busy},       32'd0);
        chk({tag, "_done"},       {31'd0, done},       32'd0);
        chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd1);
        chk({tag, "_bit_cnt"},    {29'd0, bit_cnt},    32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        div      = 8'd0;
        abort    = 1'b0;

        // exp_done = 4*(div+1)+1, exp_reg = accepted word
        vecs[0] = '{data: 4'hA, dv: 8'd0,   exp_done: 5,    exp_reg: 4'hA};
        vecs[1] = '{data: 4'h3, dv: 8'd2,   exp_done: 13,   exp_reg: 4'h3};
        vecs[2] = '{data: 4'h1, dv: 8'd1,   exp_done: 9,    exp_reg: 4'h1};
        vecs[3] = '{data: 4'h8, dv: 8'd3,   exp_done: 17,   exp_reg: 4'h8};
        vecs[4] = '{data: 4'hE, dv: 8'd255, exp_done: 1025, exp_reg: 4'hE};
        vecs[5] = '{data: 4'h0, dv: 8'd0,   exp_done: 5,    exp_reg: 4'h0};

        // Reset asserted between clock edges; outputs must clear without an edge.
        #12;
        rst = 1'b0;
        #1;
        chk_reset_vals("rst0");
        step();
        step();
        rst = 1'b1;
        step();
        chk_reset_vals("post_rst");

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i].data, vecs[i].dv, vecs[i].exp_done, vecs[i].exp_reg, 1'b0, w);
        end

        // Busy rejection: 4'h5 offered all through a 4'hC transfer.
        run_xfer(4'hC, 8'd1, 9, 4'hC, 1'b1, w);
        run_xfer(4'h5, 8'd0, 5, 4'h5, 1'b0, w);
        chk("hold_accept_wait", 32'(w), 32'd0);

        // Abort during the second bit, on the cycle it would have shifted.
        wait_ready(w);
        in_valid = 1'b1;
        in_data  = 4'hB;
        div      = 8'd1;
        step();
        in_valid = 1'b0;
        step();
        chk("ab_se_c2", {31'd0, shift_en}, 32'd1);
        step();
        chk("ab_cnt_c3", {29'd0, bit_cnt}, 32'd1);
        chk("ab_so_c3", {31'd0, serial_out}, 32'd0);
        step();
        abort = 1'b1;
        #1;
        chk("ab_se_abort", {31'd0, shift_en}, 32'd0);
        step();
        abort = 1'b0;
        chk("ab_ready", {31'd0, in_ready}, 32'd1);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_cnt", {29'd0, bit_cnt}, 32'd0);
        chk("ab_so", {31'd0, serial_out}, 32'd0);
        chk("ab_done", {31'd0, done}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("ab_no_done", {31'd0, done}, 32'd0);
        end
        run_xfer(4'h9, 8'd1, 9, 4'h9, 1'b0, w);

        // Abort on the final shift cycle beats completion.
        wait_ready(w);
        in_valid = 1'b1;
        in_data  = 4'h7;
        div      = 8'd0;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("abl_cnt_c4", {29'd0, bit_cnt}, 32'd3);
        abort = 1'b1;
        #1;
        chk("abl_se", {31'd0, shift_en}, 32'd0);
        step();
        abort = 1'b0;
        chk("abl_done", {31'd0, done}, 32'd0);
        chk("abl_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("abl_done2", {31'd0, done}, 32'd0);

        // Asynchronous reset during a 4'hF transfer.
        wait_ready(w);
        in_valid = 1'b1;
        in_data  = 4'hF;
        div      = 8'd3;
        step();
        in_valid = 1'b0;
        step();
        chk("rs_busy_pre", {31'd0, busy}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_vals("rs_mid");
        step();
        step();
        rst = 1'b1;
        step();
        chk_reset_vals("rs_rel");
        run_xfer(4'h6, 8'd0, 5, 4'h6, 1'b0, w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
